mcp_tx_side: RTL and testbench

Sending-domain half of the multi-cycle-path (MCP) clock-domain crossing. It accepts words from the a-domain producer and holds each word stable on a bus that crosses to the b domain. It signals each launch by flipping a toggle and retires the word when the returned acknowledge toggle arrives. The b-domain receiver FSM pairs with it: that FSM sees this block's toggle as its enable and returns a toggle on each load.

---
 rtl/mcp_pkg.sv | 18 +
 rtl/mcp_tx_side_tog_sync.sv | 28 ++
 rtl/mcp_tx_side.sv | 90 +++++++++
 tb/tb_mcp_tx_side.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mcp_pkg.sv
// Shared types for both halves of the multi-cycle-path crossing.
package mcp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FULL = 2'd2
  } mcp_tx_state_e;

  // Receiving-side FSM states; the b domain waits for an enable toggle, then loads.
  typedef enum logic [0:0] {
    RX_WAIT = 1'b0,
    RX_LOAD = 1'b1
  } mcp_rx_state_e;

  localparam int unsigned SYNC_STAGES = 3;

endpackage

// File: rtl/mcp_tx_side_tog_sync.sv
// Three-flop synchronizer for a toggle signal with an edge-to-pulse output.
module tog_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tog,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= tog;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s1 is the metastability catcher; only settled stages feed the edge detector.
  assign pulse = s2 ^ s3;

endmodule

// File: rtl/mcp_tx_side.sv
// Sending half of the MCP crossing: holds a word on adata, flips a_en per launch,
// retires the word on the synchronized b_ack toggle, and buffers one pending word.
module mcp_tx_side
  import mcp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic             aclk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] adatain,
  input  logic             asend,
  output logic             aready,
  output logic [WIDTH-1:0] adata,
  output logic             a_en,
  input  logic             b_ack,
  output logic             a_ack,
  output logic [CNTW-1:0]  tx_count
);

  mcp_tx_state_e    state, state_next;
  logic [WIDTH-1:0] pend, pend_next, adata_next;
  logic             launch;
  logic             ack_pulse;

  tog_sync #(.RST_VAL(1'b0)) u_ack_sync (
    .clk   (aclk),
    .rst_n (arst_n),
    .tog   (b_ack),
    .pulse (ack_pulse)
  );

  // Next-state and datapath selection; adata only moves together with a launch.
  always_comb begin
    state_next = state;
    adata_next = adata;
    pend_next  = pend;
    launch     = 1'b0;
    case (state)
      IDLE: begin
        if (asend) begin
          adata_next = adatain;
          launch     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (ack_pulse && asend) begin
          adata_next = adatain;
          launch     = 1'b1;
        end else if (ack_pulse) begin
          state_next = IDLE;
        end else if (asend) begin
          pend_next  = adatain;
          state_next = FULL;
        end
      end
      FULL: begin
        if (ack_pulse) begin
          adata_next = pend;
          launch     = 1'b1;
          state_next = BUSY;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Acks arriving with nothing in flight are spurious and dropped.
  assign a_ack = ack_pulse && (state != IDLE);

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      adata    <= '0;
      pend     <= '0;
      a_en     <= 1'b0;
      aready   <= 1'b1;
      tx_count <= '0;
    end else begin
      state    <= state_next;
      adata    <= adata_next;
      pend     <= pend_next;
      a_en     <= a_en ^ launch;
      aready   <= (state_next != FULL);
      tx_count <= tx_count + CNTW'(a_ack);
    end
  end

endmodule

// File: tb/tb_mcp_tx_side.sv
// Directed bench for mcp_tx_side with hand-computed expectations (CNTW=4 for wrap).
module tb_mcp_tx_side;
  import mcp_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNTW  = 4;

  logic             aclk = 1'b0;
  logic             arst_n = 1'b0;
  logic [WIDTH-1:0] adatain = '0;
  logic             asend = 1'b0;
  logic             aready;
  logic [WIDTH-1:0] adata;
  logic             a_en;
  logic             b_ack = 1'b0;
  logic             a_ack;
  logic [CNTW-1:0]  tx_count;

  int checks = 0;
  int errors = 0;
  logic exp_en = 1'b0;
  int   exp_cnt = 0;

  mcp_tx_side #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .aclk     (aclk),
    .arst_n   (arst_n),
    .adatain  (adatain),
    .asend    (asend),
    .aready   (aready),
    .adata    (adata),
    .a_en     (a_en),
    .b_ack    (b_ack),
    .a_ack    (a_ack),
    .tx_count (tx_count)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    asend   = 1'b1;
    adatain = d;
    step();
    asend   = 1'b0;
  endtask

  // Flip b_ack and verify the a_ack pulse timing and the count on retirement.
  task automatic ack_word(input string tag);
    b_ack = ~b_ack;
    step();
    check_eq({tag, "_ack_k"}, 32'(a_ack), 32'd0);
    step();
    check_eq({tag, "_ack_k1"}, 32'(a_ack), 32'd1);
    step();
    exp_cnt = (exp_cnt + 1) % 16;
    check_eq({tag, "_ack_k2"}, 32'(a_ack), 32'd0);
    check_eq({tag, "_count"}, 32'(tx_count), 32'(exp_cnt));
  endtask

  initial begin
    logic [WIDTH-1:0] d0, d1;

    // Reset with activity on the inputs
    asend = 1'b1;
    adatain = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      b_ack = ~b_ack;
      step();
    end
    check_eq("rst_aready", 32'(aready), 32'd1);
    check_eq("rst_a_en", 32'(a_en), 32'd0);
    check_eq("rst_adata", 32'(adata), 32'd0);
    check_eq("rst_a_ack", 32'(a_ack), 32'd0);
    check_eq("rst_count", 32'(tx_count), 32'd0);
    asend = 1'b0;
    arst_n = 1'b1;
    step();
    step();

    // Single transfer
    send(8'hA5);
    exp_en = ~exp_en;
    check_eq("single_adata", 32'(adata), 32'hA5);
    check_eq("single_a_en", 32'(a_en), 32'(exp_en));
    check_eq("single_aready", 32'(aready), 32'd1);
    ack_word("single");
    check_eq("single_state", 32'(dut.state), 32'(IDLE));

    // Buffering: 0x11 in flight, 0x22 pending, 0x33 ignored
    send(8'h11);
    exp_en = ~exp_en;
    send(8'h22);
    check_eq("buf_aready_full", 32'(aready), 32'd0);
    check_eq("buf_adata_held", 32'(adata), 32'h11);
    send(8'h33);
    check_eq("buf_ignore_adata", 32'(adata), 32'h11);
    check_eq("buf_ignore_aready", 32'(aready), 32'd0);
    check_eq("buf_ignore_a_en", 32'(a_en), 32'(exp_en));
    ack_word("buf1");
    exp_en = ~exp_en;
    check_eq("buf_adata_pend", 32'(adata), 32'h22);
    check_eq("buf_a_en", 32'(a_en), 32'(exp_en));
    check_eq("buf_aready", 32'(aready), 32'd1);
    ack_word("buf2");
    check_eq("buf_state_idle", 32'(dut.state), 32'(IDLE));
    check_eq("buf_adata_final", 32'(adata), 32'h22);

    // Simultaneous ack and send in BUSY
    send(8'h55);
    exp_en = ~exp_en;
    b_ack = ~b_ack;
    step();
    step();
    check_eq("sim_a_ack", 32'(a_ack), 32'd1);
    asend = 1'b1;
    adatain = 8'h44;
    step();
    asend = 1'b0;
    exp_en = ~exp_en;
    exp_cnt = exp_cnt + 1;
    check_eq("sim_adata", 32'(adata), 32'h44);
    check_eq("sim_a_en", 32'(a_en), 32'(exp_en));
    check_eq("sim_state", 32'(dut.state), 32'(BUSY));
    check_eq("sim_aready", 32'(aready), 32'd1);
    check_eq("sim_count", 32'(tx_count), 32'(exp_cnt));
    ack_word("sim2");

    // Spurious ack in IDLE
    b_ack = ~b_ack;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("spur_a_ack", 32'(a_ack), 32'd0);
    end
    check_eq("spur_count", 32'(tx_count), 32'(exp_cnt));

    // Reset while FULL
    send(8'h66);
    send(8'h77);
    check_eq("midrst_full", 32'(aready), 32'd0);
    arst_n = 1'b0;
    b_ack = 1'b0;
    #1;
    check_eq("midrst_aready", 32'(aready), 32'd1);
    check_eq("midrst_a_en", 32'(a_en), 32'd0);
    check_eq("midrst_adata", 32'(adata), 32'd0);
    check_eq("midrst_count", 32'(tx_count), 32'd0);
    check_eq("midrst_state", 32'(dut.state), 32'(IDLE));
    step();
    arst_n = 1'b1;
    exp_en = 1'b0;
    exp_cnt = 0;
    step();

    // 16 transfers in buffered pairs; order and wrap
    for (int p = 0; p < 8; p++) begin
      d0 = WIDTH'(8'h10 + p * 2);
      d1 = WIDTH'(8'h10 + p * 2 + 1);
      send(d0);
      exp_en = ~exp_en;
      check_eq("wrap_first", 32'(adata), 32'(d0));
      send(d1);
      check_eq("wrap_full", 32'(aready), 32'd0);
      ack_word("wrap_a");
      exp_en = ~exp_en;
      check_eq("wrap_second", 32'(adata), 32'(d1));
      check_eq("wrap_a_en", 32'(a_en), 32'(exp_en));
      ack_word("wrap_b");
    end
    check_eq("wrap_count_zero", 32'(tx_count), 32'd0);
    check_eq("wrap_state", 32'(dut.state), 32'(IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
